// File: rtl/cacheline_adapter_pkg.sv
// Shared constants and state encoding for the D-cache to burst-memory line adapter.
package cacheline_adapter_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned BURST_BEATS = 4;
  localparam int unsigned CNT_W       = $clog2(BURST_BEATS);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Splits 256-bit cache line fills/write-backs into four 64-bit bursts on the memory port.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  adapter_state_t    state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rbuf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          // Write-back wins over a simultaneous fill request.
          if (dfp_write) begin
            addr_q  <= dfp_addr;
            wline_q <= dfp_wdata;
            cnt     <= '0;
          end else if (dfp_read) begin
            addr_q <= dfp_addr;
            cnt    <= '0;
          end
        end
        RD_WAIT: begin
          if (bmem_rvalid) begin
            rbuf_q[cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
            cnt <= cnt + 1'b1;
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    dfp_resp   = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (dfp_write) begin
          state_next = WR_BURST;
        end else if (dfp_read) begin
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bmem_rvalid && cnt == LAST_BEAT) begin
          state_next = RD_DONE;
        end
      end
      RD_DONE: begin
        dfp_resp   = 1'b1;
        state_next = IDLE;
      end
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wline_q[cnt*BEAT_W +: BEAT_W];
        if (bmem_ready && cnt == LAST_BEAT) begin
          state_next = WR_DONE;
        end
      end
      WR_DONE: begin
        dfp_resp   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dfp_rdata = rbuf_q;

endmodule
